uart_rx_unit: RTL and testbench
===============================

Name: uart_rx_unit

Overview:
Serial-to-parallel UART receiver with an integrated 16x-oversampling baud tick generator. It sits directly upstream of the receive FIFO.
- rx_done_tick drives the FIFO controller's wr command.
- dout drives the FIFO write-data port.
Each received frame produces exactly one one-cycle write pulse. Frame format is 1 start bit, DBIT data bits LSB first, and a stop period of SB_TICK oversample ticks.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, stop period length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
DVSR_WIDTH, 11, width of the baud divisor input

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
dvsr  input  DVSR_WIDTH  baud divisor; oversample tick period = dvsr+1 clocks
rx  input  1  serial line, idle high, asynchronous to clk
rx_done_tick  output  1  one-cycle pulse when a frame completes (FIFO wr)
dout  output  DBIT  last received data word
frame_err  output  1  one-cycle pulse coincident with rx_done_tick when the stop bit sampled low

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - tick counter = 0
  - s (oversample count) = 0, n (bit count) = 0, shift register = 0
  - rx synchronizer flops = 1
  - rx_done_tick = 0, frame_err = 0, dout = 0
- Reset asserted mid-frame aborts the frame with no done pulse. The partially shifted data is discarded.
- rx synchronizer: 2-flop chain resetting to 1. The FSM sees rx_s, which lags rx by 2 cycles.
- Tick generator:
  - Free-running counter, 0..dvsr.
  - tick = 1 for one cycle when counter == dvsr; counter then returns to 0.
  - dvsr = 0 gives a tick every cycle.
  - A dvsr change takes effect on the next wrap. Comparison uses the current dvsr; if the counter is already above a new smaller dvsr, it counts up, wraps at its width, then matches.
- FSM states: IDLE, START, DATA, STOP. s is 4 bits in START/DATA; it is widened to hold SB_TICK-1 in STOP.
  - IDLE: when rx_s == 0 -> START, s = 0. No tick required.
  - START: on each tick, s++. At tick with s == 7 (mid start bit):
    - rx_s == 0 -> DATA, s = 0, n = 0
    - else -> IDLE (glitch rejection, no output)
  - DATA: on each tick, s++. At tick with s == 15 (mid bit):
    - shift register = {rx_s, shift[DBIT-1:1]}, s = 0
    - n == DBIT-1 -> STOP, else n++
  - STOP: on each tick, s++. At tick with s == SB_TICK-1:
    - rx_done_tick = 1 next cycle for exactly one cycle
    - dout <= assembled word
    - frame_err = ~rx_s for the same cycle
    - -> IDLE
- Latency: done pulse occurs one clk after the tick at the middle of the (first) stop bit, plus the 2-cycle synchronizer lag.
- Output hold: dout holds its value until the next completed frame. A frame error still updates dout and still pulses rx_done_tick; downstream gating is the consumer's choice.
- Back-to-back frames: IDLE re-arms immediately, so a start edge right after the stop sample is accepted with no gap.
- Line held low continuously (break): each frame completes with frame_err = 1; IDLE then restarts immediately because rx_s stays low.
- Ticks arriving in IDLE are ignored. s counts only on ticks, not on clk.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - adds state PARITY between DATA and STOP, one bit time long, sampled at s == 15
  - adds output port parity_err (1 bit): a one-cycle pulse coincident with rx_done_tick when even parity over the DBIT data bits plus the parity bit fails
  - reset value of parity_err = 0
- Not defined: no PARITY state and no parity_err port; DATA goes directly to STOP.

Test Plan:
- Single frame: dvsr = 3 (bit = 64 clk), send 0xA5 with 1 stop bit -> exactly one rx_done_tick, dout = 0xA5, frame_err = 0, pulse within the stop bit window.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap -> two done pulses, dout = 0x00 then 0xFF, no missed or extra pulses.
- Glitch rejection: rx low for 3 ticks (12 clk) then high -> no rx_done_tick, FSM back to IDLE; a subsequent 0x3C frame is received correctly.
- Framing error: send 0x5A with stop bit forced 0 -> rx_done_tick = 1 and frame_err = 1 in the same cycle, dout = 0x5A.
- Reset mid-frame: assert reset during data bit 4 of 0xC3 -> outputs 0 immediately, no done pulse; the next full frame 0x81 is received with dout = 0x81.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> parity_err = 0; send 0x07 with parity bit 0 -> parity_err = 1 coincident with done, dout = 0x07 in both cases.

Source files
------------

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x-oversampled UART receiver with integrated baud tick generator.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module uart_rx_unit #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    input  logic                  rx,
    output logic                  rx_done_tick,
    output logic [DBIT-1:0]       dout,
    output logic                  frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state;
    logic [DVSR_WIDTH-1:0] cnt;
    logic                  tick;
    logic                  rx_q, rx_s;
    logic [SW-1:0]         s;
    logic [NW-1:0]         n;
    logic [DBIT-1:0]       shreg;
`ifdef UART_RX_PARITY_EN
    logic                  par;
`endif
    assign tick = (cnt == dvsr);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    // rx is asynchronous to clk; idle-high reset keeps a false start from appearing
    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_s, rx_q} <= 2'b11;
        else {rx_s, rx_q} <= {rx_q, rx};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par          <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
`endif
            case (state)
                IDLE:
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                START:
                    if (tick) begin
                        if (s == SW'(7)) begin
                            state <= rx_s ? IDLE : DATA;
                            s     <= '0;
                            n     <= '0;
                        end else s <= s + 1'b1;
                    end
                DATA:
                    if (tick) begin
                        if (s == SW'(15)) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            if (n == NW'(DBIT - 1))
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            else n <= n + 1'b1;
                        end else s <= s + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                PARITY:
                    if (tick) begin
                        if (s == SW'(15)) begin
                            s     <= '0;
                            par   <= rx_s;
                            state <= STOP;
                        end else s <= s + 1'b1;
                    end
`endif
                STOP:
                    if (tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            dout         <= shreg;
                            rx_done_tick <= 1'b1;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= ^{shreg, par};
`endif
                        end else s <= s + 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: directed self-checking bench for uart_rx_unit at dvsr = 3 (64 clk per bit).
// Define UART_RX_PARITY_EN to also exercise the parity bit and parity_err.
module tb_uart_rx_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] dvsr = 11'd3;
    logic        rx = 1'b1;
    logic        rx_done_tick;
    logic [7:0]  dout;
    logic        frame_err;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          stop_start = 0;
    logic [7:0]  hist_d [0:31];
    logic        hist_fe [0:31];
    logic        hist_pe [0:31];
    int          hist_cyc [0:31];

    uart_rx_unit #(.DBIT(8), .SB_TICK(16), .DVSR_WIDTH(11)) dut (
        .clk(clk),
        .reset(reset),
        .dvsr(dvsr),
        .rx(rx),
        .rx_done_tick(rx_done_tick),
        .dout(dout),
        .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (rx_done_tick) begin
            if (done_cnt < 32) begin
                hist_d[done_cnt]   = dout;
                hist_fe[done_cnt]  = frame_err;
                hist_cyc[done_cnt] = cyc;
`ifdef UART_RX_PARITY_EN
                hist_pe[done_cnt]  = parity_err;
`else
                hist_pe[done_cnt]  = 1'b0;
`endif
            end
            done_cnt++;
        end

    task automatic wait_clks(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit, input int gap);
        rx = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(64);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clks(64);
`endif
        rx = stop_bit;
        stop_start = cyc;
        wait_clks(64);
        rx = 1'b1;
        wait_clks(gap);
    endtask

    task automatic test_reset;
        rx = 1'b1;
        reset = 1'b1;
        wait_clks(5);
        checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", rx_done_tick); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_err); end
        reset = 1'b0;
        wait_clks(20);
    endtask

    task automatic test_single;
        int base = done_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 100);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL single_count got %0d want %0d", done_cnt - base, 1); end
        checks++; if (hist_d[base] !== 8'hA5) begin errors++; $display("FAIL single_dout got %h want a5", hist_d[base]); end
        checks++; if (hist_fe[base] !== 1'b0) begin errors++; $display("FAIL single_fe got %b want 0", hist_fe[base]); end
        checks++; if (!(hist_cyc[base] > stop_start && hist_cyc[base] < stop_start + 64)) begin
            errors++; $display("FAIL single_window pulse cycle %0d want in (%0d,%0d)", hist_cyc[base], stop_start, stop_start + 64);
        end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", dout); end
    endtask

    task automatic test_back_to_back;
        int base = done_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 100);
        checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL b2b_count got %0d want 2", done_cnt - base); end
        checks++; if (hist_d[base] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", hist_d[base]); end
        checks++; if (hist_d[base + 1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", hist_d[base + 1]); end
        checks++; if (hist_fe[base] !== 1'b0 || hist_fe[base + 1] !== 1'b0) begin
            errors++; $display("FAIL b2b_fe got %b%b want 00", hist_fe[base], hist_fe[base + 1]);
        end
    endtask

    task automatic test_glitch;
        int base = done_cnt;
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(200);
        checks++; if (done_cnt !== base) begin errors++; $display("FAIL glitch_nopulse got %0d pulses want 0", done_cnt - base); end
        send_frame(8'h3C, 1'b0, 1'b1, 100);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", done_cnt - base); end
        checks++; if (hist_d[base] !== 8'h3C) begin errors++; $display("FAIL glitch_next_dout got %h want 3c", hist_d[base]); end
    endtask

    task automatic test_frame_err;
        int base = done_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 200);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL ferr_count got %0d want 1", done_cnt - base); end
        checks++; if (hist_fe[base] !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", hist_fe[base]); end
        checks++; if (hist_d[base] !== 8'h5A) begin errors++; $display("FAIL ferr_dout got %h want 5a", hist_d[base]); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_pulse_len got %b want 0", frame_err); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d = 8'hC3;
        int base = done_cnt;
        rx = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clks(64);
        end
        rx = d[4];
        wait_clks(32);
        reset = 1'b1;
        #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got %h want 00", dout); end
        checks++; if (rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got %b%b want 00", rx_done_tick, frame_err);
        end
        wait_clks(5);
        rx = 1'b1;
        reset = 1'b0;
        wait_clks(300);
        checks++; if (done_cnt !== base) begin errors++; $display("FAIL rstmid_nopulse got %0d want 0", done_cnt - base); end
        send_frame(8'h81, 1'b0, 1'b1, 100);
        checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL rstmid_next_count got %0d want 1", done_cnt - base); end
        checks++; if (hist_d[base] !== 8'h81) begin errors++; $display("FAIL rstmid_next_dout got %h want 81", hist_d[base]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int base = done_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 100);
        send_frame(8'h07, 1'b0, 1'b1, 100);
        checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL par_count got %0d want 2", done_cnt - base); end
        checks++; if (hist_pe[base] !== 1'b0) begin errors++; $display("FAIL par_good got %b want 0", hist_pe[base]); end
        checks++; if (hist_pe[base + 1] !== 1'b1) begin errors++; $display("FAIL par_bad got %b want 1", hist_pe[base + 1]); end
        checks++; if (hist_d[base] !== 8'h07 || hist_d[base + 1] !== 8'h07) begin
            errors++; $display("FAIL par_dout got %h %h want 07 07", hist_d[base], hist_d[base + 1]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
